// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin owner/sequencer for the shared snooping bus
//
// Purpose: grants the shared bus to one cache controller at a time, broadcasts
// its request as bus_msg, holds ownership until memory answers (or a timeout
// expires) for data-carrying transactions, then pulses done_out to the owner.
//
// Ports:
//   clk        clock
//   rst        asynchronous, active-high reset
//   req_in     per-requester bus request, pending while .valid
//   mem_resp   memory response, observed only
//   bus_msg    registered broadcast, .valid for one cycle per transaction
//   grant_out  one-hot grant, coincident with bus_msg.valid
//   done_out   one-hot end-of-tenure pulse to the owner
//   err_out    end-of-tenure by timeout, coincident with done_out
//   busy       high while a tenure is in progress (BCAST or WAIT)

package bus_pkg;
    localparam int NUM_CPUS = 4;
    localparam int ADDR_W   = 16;
    localparam int SRC_W    = $clog2(NUM_CPUS);

    typedef enum logic [1:0] {
        Bus_Rd   = 2'd0,
        Bus_RdX  = 2'd1,
        Bus_Upgr = 2'd2,
        Bus_Wb   = 2'd3
    } bus_tx_t;

    typedef struct packed {
        logic              valid;
        bus_tx_t           bus_tx;
        logic [ADDR_W-1:0] addr;
        logic [SRC_W-1:0]  source;
    } bus_msg_t;

    typedef struct packed {
        logic              valid;
        logic [SRC_W-1:0]  destination;
        logic [ADDR_W-1:0] addr;
    } xbar_msg_t;
endpackage

module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_REQ        = NUM_CPUS,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  bus_msg_t           req_in [NUM_REQ],
    input  xbar_msg_t          mem_resp,
    output bus_msg_t           bus_msg,
    output logic [NUM_REQ-1:0] grant_out,
    output logic [NUM_REQ-1:0] done_out,
    output logic               err_out,
    output logic               busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BCAST = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [CNT_W-1:0]   cnt;

    logic               found;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   ptr_next;
    logic               resp_match;
    logic               needs_data;
    int                 rr_idx;

    // Scan offsets from the far end back toward ptr so that the last hit,
    // i.e. the first valid index at or after ptr, is the one that sticks.
    always_comb begin
        found  = 1'b0;
        win    = '0;
        idx    = '0;
        rr_idx = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            rr_idx = int'(ptr) + i;
            if (rr_idx >= NUM_REQ) begin
                rr_idx = rr_idx - NUM_REQ;
            end
            idx = IDX_W'(rr_idx);
            if (req_in[idx].valid) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign ptr_next   = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    assign needs_data = (bus_msg.bus_tx == Bus_Rd) || (bus_msg.bus_tx == Bus_RdX);

    // Only a response for this owner and the latched address ends the tenure.
    assign resp_match = mem_resp.valid
                     && (mem_resp.destination == SRC_W'(owner))
                     && (mem_resp.addr == bus_msg.addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            cnt       <= '0;
            bus_msg   <= '0;
            grant_out <= '0;
            done_out  <= '0;
            err_out   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            grant_out     <= '0;
            done_out      <= '0;
            err_out       <= 1'b0;
            bus_msg.valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (found) begin
                        state          <= BCAST;
                        bus_msg        <= req_in[win];
                        bus_msg.valid  <= 1'b1;
                        bus_msg.source <= SRC_W'(win);
                        owner          <= win;
                        ptr            <= ptr_next;
                        grant_out      <= NUM_REQ'(1) << win;
                        busy           <= 1'b1;
                    end
                end

                BCAST: begin
                    if (needs_data) begin
                        state <= WAIT;
                        cnt   <= '0;
                    end else begin
                        state    <= IDLE;
                        done_out <= NUM_REQ'(1) << owner;
                        busy     <= 1'b0;
                    end
                end

                WAIT: begin
                    if (resp_match) begin
                        state    <= IDLE;
                        done_out <= NUM_REQ'(1) << owner;
                        busy     <= 1'b0;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state    <= IDLE;
                        done_out <= NUM_REQ'(1) << owner;
                        err_out  <= 1'b1;
                        busy     <= 1'b0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    bus_msg_t   req [N];
    xbar_msg_t  mem;
    bus_msg_t   bus_msg;
    logic [N-1:0] grant_out;
    logic [N-1:0] done_out;
    logic       err_out;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req),
        .mem_resp  (mem),
        .bus_msg   (bus_msg),
        .grant_out (grant_out),
        .done_out  (done_out),
        .err_out   (err_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input bus_tx_t tx, input logic [15:0] a);
        req[i].valid  = v;
        req[i].bus_tx = tx;
        req[i].addr   = a;
        req[i].source = 2'd3;
    endtask

    task automatic set_mem(input logic v, input logic [1:0] d, input logic [15:0] a);
        mem.valid       = v;
        mem.destination = d;
        mem.addr        = a;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, Bus_Rd, 16'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    bus_msg_t exp_msg;
    int       who;

    initial begin
        clear_reqs();
        set_mem(1'b0, 2'd0, 16'h0);
        do_reset();

        // Reset state
        check("rst_bus_msg", 64'(bus_msg), 64'h0);
        check("rst_grant", 64'(grant_out), 64'h0);
        check("rst_done", 64'(done_out), 64'h0);
        check("rst_err", 64'(err_out), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);

        // Single Bus_Rd from CPU2 at 0x5; requester's source field is bogus
        set_req(2, 1'b1, Bus_Rd, 16'h5);
        step();
        exp_msg = '{valid: 1'b1, bus_tx: Bus_Rd, addr: 16'h5, source: 2'd2};
        check("t1_bus_msg", 64'(bus_msg), 64'(exp_msg));
        check("t1_grant", 64'(grant_out), 64'b0100);
        check("t1_busy", 64'(busy), 64'h1);
        clear_reqs();
        step();
        check("t1_valid_drop", 64'(bus_msg.valid), 64'h0);
        check("t1_grant_drop", 64'(grant_out), 64'h0);
        check("t1_wait_busy", 64'(busy), 64'h1);
        set_mem(1'b1, 2'd2, 16'h5);
        step();
        set_mem(1'b0, 2'd0, 16'h0);
        check("t1_done", 64'(done_out), 64'b0100);
        check("t1_err", 64'(err_out), 64'h0);
        check("t1_busy_end", 64'(busy), 64'h0);
        check("t1_addr_held", 64'(bus_msg.addr), 64'h5);
        step();
        check("t1_done_pulse", 64'(done_out), 64'h0);

        // All four request continuously: order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, Bus_Rd, 16'h10 + 16'(i));
        for (int k = 0; k < 5; k++) begin
            who = k % N;
            step();
            check($sformatf("rr%0d_grant", k), 64'(grant_out), 64'(1) << who);
            check($sformatf("rr%0d_src", k), 64'(bus_msg.source), 64'(who));
            check($sformatf("rr%0d_addr", k), 64'(bus_msg.addr), 64'h10 + 64'(who));
            step();
            check($sformatf("rr%0d_nogrant", k), 64'(grant_out), 64'h0);
            set_mem(1'b1, 2'(who), 16'h10 + 16'(who));
            if (k == 4) clear_reqs();
            step();
            set_mem(1'b0, 2'd0, 16'h0);
            check($sformatf("rr%0d_done", k), 64'(done_out), 64'(1) << who);
            check($sformatf("rr%0d_valid0", k), 64'(bus_msg.valid), 64'h0);
        end

        // Bus_Upgr from CPU1 with a stray matching mem_resp throughout
        set_req(1, 1'b1, Bus_Upgr, 16'h20);
        set_mem(1'b1, 2'd1, 16'h20);
        step();
        check("up_grant", 64'(grant_out), 64'b0010);
        check("up_tx", 64'(bus_msg.bus_tx), 64'(Bus_Upgr));
        check("up_valid", 64'(bus_msg.valid), 64'h1);
        clear_reqs();
        step();
        check("up_done", 64'(done_out), 64'b0010);
        check("up_err", 64'(err_out), 64'h0);
        check("up_busy", 64'(busy), 64'h0);
        step();
        set_mem(1'b0, 2'd0, 16'h0);
        check("up_done_pulse", 64'(done_out), 64'h0);
        check("up_no_regrant", 64'(grant_out), 64'h0);

        // Bus_RdX from CPU0, memory silent: timeout after 8 WAIT cycles
        set_req(0, 1'b1, Bus_RdX, 16'h33);
        step();
        check("to_grant", 64'(grant_out), 64'b0001);
        clear_reqs();
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("to_wait%0d_done", k), 64'(done_out), 64'h0);
            check($sformatf("to_wait%0d_busy", k), 64'(busy), 64'h1);
        end
        step();
        check("to_done", 64'(done_out), 64'b0001);
        check("to_err", 64'(err_out), 64'h1);
        check("to_busy", 64'(busy), 64'h0);
        step();
        check("to_err_pulse", 64'(err_out), 64'h0);

        // Owner 3 in WAIT: wrong destination, wrong address, then correct
        set_req(3, 1'b1, Bus_Rd, 16'h44);
        step();
        check("w3_grant", 64'(grant_out), 64'b1000);
        clear_reqs();
        step();
        set_mem(1'b1, 2'd1, 16'h44);
        step();
        check("w3_bad_dest", 64'(done_out), 64'h0);
        set_mem(1'b1, 2'd3, 16'h45);
        step();
        check("w3_bad_addr", 64'(done_out), 64'h0);
        check("w3_still_busy", 64'(busy), 64'h1);
        set_mem(1'b1, 2'd3, 16'h44);
        step();
        set_mem(1'b0, 2'd0, 16'h0);
        check("w3_done", 64'(done_out), 64'b1000);
        check("w3_err", 64'(err_out), 64'h0);

        // Async reset in WAIT, then CPUs 1 and 0 request: CPU0 first
        set_req(2, 1'b1, Bus_Rd, 16'h66);
        step();
        check("ar_grant", 64'(grant_out), 64'b0100);
        clear_reqs();
        step();
        #2 rst = 1'b1;
        #1;
        check("ar_busy", 64'(busy), 64'h0);
        check("ar_bus_msg", 64'(bus_msg), 64'h0);
        check("ar_done", 64'(done_out), 64'h0);
        set_req(1, 1'b1, Bus_Rd, 16'h71);
        set_req(0, 1'b1, Bus_Rd, 16'h70);
        step();
        check("ar_hold_done", 64'(done_out), 64'h0);
        rst = 1'b0;
        step();
        check("ar_first_grant", 64'(grant_out), 64'b0001);
        set_req(0, 1'b0, Bus_Rd, 16'h0);
        step();
        set_mem(1'b1, 2'd0, 16'h70);
        step();
        set_mem(1'b0, 2'd0, 16'h0);
        check("ar_done0", 64'(done_out), 64'b0001);
        step();
        check("ar_second_grant", 64'(grant_out), 64'b0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter and sequencer for the shared snooping bus. It sits between the per-CPU cache controllers and the single `bus_msg` broadcast seen by memory and all snoopers. It grants the bus to one requester at a time and holds ownership for the whole transaction: broadcast, then the memory data response where one is needed. It then signals completion to the owner and rotates priority.

## Interface
- `NUM_REQ`, default `NUM_CPUS`: number of requesters.
- `TIMEOUT_CYCLES`, default 64: maximum cycles spent in WAIT before forced release.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `req_in[NUM_REQ]`  in  `bus_msg_t`: per-CPU request. Pending while `.valid`=1. Fields are held stable until grant.
- `mem_resp`  in  `xbar_msg_t`: memory response (memory's `xbar_out`), observed only.
- `bus_msg`  out  `bus_msg_t`: registered bus broadcast. `.valid` is high for exactly one cycle per transaction.
- `grant_out`  out  `NUM_REQ`: one-hot. Pulses in the same cycle as `bus_msg.valid`.
- `done_out`  out  `NUM_REQ`: one-hot, one-cycle pulse to the owner at end of tenure.
- `err_out`  out  1: one-cycle pulse with `done_out` when tenure ends by timeout.
- `busy`  out  1: high in BCAST and WAIT.

## Operation
- State machine has three states: IDLE, BCAST, WAIT.
- **IDLE**
  - If any `req_in[i].valid`, select winner `w` by round-robin starting at pointer `ptr`: the first valid index in `ptr, ptr+1, …` mod `NUM_REQ`.
  - Next state BCAST.
  - Latch `req_in[w]` into `bus_msg`. Force `bus_msg.source = w`; the requester's source field is ignored.
  - Latch `owner = w`, `ptr = (w+1) mod NUM_REQ`, `grant_out = 1<<w`.
- **BCAST** (`bus_msg.valid`=1 this cycle)
  - If `bus_tx` is `Bus_Rd` or `Bus_RdX`: next state WAIT, clear the timeout counter.
  - Any other `bus_tx` (e.g. `Bus_Upgr`) needs no data: next state IDLE, pulse `done_out[owner]`.
- **WAIT**
  - Completion condition: `mem_resp.valid && mem_resp.destination == owner && mem_resp.addr == bus_msg.addr` (latched address).
  - On completion: next state IDLE, pulse `done_out[owner]`.
  - Otherwise the counter increments. When the counter reaches `TIMEOUT_CYCLES - 1` without a response: next state IDLE, pulse `done_out[owner]` and `err_out`.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)` and it saturates, never wraps.
- `bus_msg` fields other than `.valid` hold their latched values through WAIT. `.valid` is 0 outside BCAST.
- A `mem_resp` with `.valid` in IDLE or BCAST, or with non-matching destination or address, is ignored and has no effect.
- Requesters drop `.valid` no later than the cycle after `grant_out`. A requester still valid in the next IDLE is treated as a new request; fairness is still preserved because `ptr` has advanced past it.
- Simultaneous requests: exactly one grant per arbitration, never more than one bit set in `grant_out` or `done_out`.
- A request arriving during BCAST or WAIT waits; it is evaluated in the next IDLE cycle.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `ptr`=0, `owner`=0, counter 0, `bus_msg`='0, `grant_out`=0, `done_out`=0, `err_out`=0, `busy`=0.
- Reset asserted mid-transaction aborts immediately. No `done_out` is issued for the aborted tenure.
- Request sampled in IDLE at cycle t gives `bus_msg.valid`/`grant_out` at t+1.
- Memory responds at t+2, giving `done_out` at t+3, which is IDLE again. The next `bus_msg.valid` is at t+4 at the earliest.
- Data-less transaction: `bus_msg` at t+1, `done_out` at t+2, which is IDLE.
- Minimum spacing between broadcasts is 3 cycles for `Bus_Rd`/`Bus_RdX` and 2 cycles otherwise.

## Test plan
- Reset, then single `Bus_Rd` from CPU2 at addr 0x5:
  - `bus_msg` = {valid, `Bus_Rd`, 0x5, src 2} and `grant_out`=4'b0100 one cycle later.
  - Memory responds with dest 2 → `done_out`=4'b0100 next cycle; `busy` returns to 0.
- All 4 CPUs request simultaneously and continuously: grant order 0,1,2,3,0 with no duplicate or missing grants; each tenure completes before the next `bus_msg.valid`.
- `Bus_Upgr` from CPU1 → `bus_msg.valid` for 1 cycle, `done_out[1]` the next cycle, no WAIT; a stray `mem_resp` during this is ignored.
- `Bus_RdX` from CPU0 with memory silent, `TIMEOUT_CYCLES`=8 → after 8 WAIT cycles `done_out[0]` and `err_out` pulse together; state is IDLE.
- In WAIT for owner 3, inject `mem_resp` with dest 1, then with dest 3 but wrong addr → no completion. Correct response → `done_out[3]`.
- Assert `rst` asynchronously mid-WAIT → all outputs 0 immediately, `ptr`=0. With CPUs 1 and 0 requesting after release, CPU0 is granted first.
